// File: rtl/md_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl_pkg
//
// Shared definitions for the multiply/divide issue controller:
//   - OP_W        : width of the request / unit opcode field
//   - md_op_e     : request opcode encoding (MD_MULT .. MD_MFLO)
//   - md_start_e  : MdStart command encoding (START_NONE/START_MD/START_HILO)
//   - md_state_e  : controller FSM state encoding
//   - op_is_*     : small opcode classification helpers
// ---------------------------------------------------------------------------
package md_issue_ctrl_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        START_NONE = 2'd0,
        START_MD   = 2'd1,
        START_HILO = 2'd2
    } md_start_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } md_state_e;

    // Operations that occupy the unit for a multi-cycle busy window
    function automatic logic op_is_muldiv(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // mfhi/mflo never reach the unit; they are served straight from HI/LO
    function automatic logic op_is_read(input logic [OP_W-1:0] op);
        return (op == MD_MFHI) || (op == MD_MFLO);
    endfunction

endpackage

// File: rtl/md_latency_check.sv
// ---------------------------------------------------------------------------
// md_latency_check
//
// Tracks the unit's busy window while the controller is in WAIT. Counts the
// edges on which busy is high, compares the count against the expected
// latency when busy falls, and aborts the wait if busy never drops.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   in_wait    in   controller is in the WAIT state
//   busy       in   unit busy flag (MdBusy)
//   expected   in   expected busy length for the issued operation
//   done       out  WAIT ends this cycle (busy low or timeout)
//   violation  out  busy fell at the wrong count, or the timeout was hit
// ---------------------------------------------------------------------------
module md_latency_check
    import md_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_wait,
    input  logic             busy,
    input  logic [CNT_W-1:0] expected,
    output logic             done,
    output logic             violation
);

    logic [CNT_W-1:0] count;
    logic             timeout_hit;

    // The count would reach TIMEOUT on this edge, so the wait is abandoned now
    assign timeout_hit = in_wait && busy && (count == CNT_W'(TIMEOUT - 1));

    assign done      = in_wait && (!busy || timeout_hit);
    assign violation = in_wait && ((!busy && (count != expected)) || timeout_hit);

    // Counter only runs across consecutive busy WAIT cycles; any exit from
    // WAIT (busy low or timeout) leaves it at zero for the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (in_wait && busy && !timeout_hit) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
//
// Pipeline-side initiator for the multiply/divide unit. Accepts md-class
// instructions from EX, issues start pulses/opcodes/operands to the unit,
// stalls the pipeline while a result is pending, serves mfhi/mflo directly
// from the unit's HI/LO registers, cancels an issue on Flush and raises a
// sticky Error on protocol or latency violations.
//
// Parameters:
//   MULT_CYCLES  busy length expected for mult/multu
//   DIV_CYCLES   busy length expected for div/divu
//   TIMEOUT      WAIT-cycle limit before giving up on the unit
//
// Ports:
//   Clock, Reset_n      clock, asynchronous active-low reset
//   ReqValid/ReqOp      EX-stage md-class request and its opcode
//   ReqRs/ReqRt         request operands
//   Flush               kill the EX instruction
//   Stall               freeze F/D/E (combinational)
//   MdStart/MdEnable    start command to the unit and its qualifier
//   MdOp/MdRD1/MdRD2    opcode and operands presented to the unit
//   MdBusy/MdHI/MdLO    unit busy flag and result registers
//   ReadData/ReadValid  mfhi/mflo result (combinational)
//   Error               sticky violation flag
// ---------------------------------------------------------------------------
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int TIMEOUT     = 16
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            ReqValid,
    input  logic [OP_W-1:0] ReqOp,
    input  logic [31:0]     ReqRs,
    input  logic [31:0]     ReqRt,
    input  logic            Flush,
    output logic            Stall,
    output logic [1:0]      MdStart,
    output logic            MdEnable,
    output logic [OP_W-1:0] MdOp,
    output logic [31:0]     MdRD1,
    output logic [31:0]     MdRD2,
    input  logic            MdBusy,
    input  logic [31:0]     MdHI,
    input  logic [31:0]     MdLO,
    output logic [31:0]     ReadData,
    output logic            ReadValid,
    output logic            Error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

    md_state_e        state, state_next;
    md_start_e        start_q, start_next;
    logic [OP_W-1:0]  op_q, op_next;
    logic [31:0]      rd1_q, rd1_next;
    logic [31:0]      rd2_q, rd2_next;
    logic [CNT_W-1:0] exp_lat_q, exp_lat_next;
    logic             error_q, error_next;

    logic free;
    logic accept;
    logic lat_done;
    logic lat_violation;

    // WAIT with the unit idle is treated exactly like IDLE, so a new request
    // can be taken in the same cycle the previous result becomes available.
    assign free   = (state == ST_IDLE) || ((state == ST_WAIT) && !MdBusy);
    assign accept = free && ReqValid && !Flush;

    md_latency_check #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_latency_check (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .in_wait   (state == ST_WAIT),
        .busy      (MdBusy),
        .expected  (exp_lat_q),
        .done      (lat_done),
        .violation (lat_violation)
    );

    // State and issue registers; everything returns to zero on reset so an
    // interrupted operation is simply dropped.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            start_q   <= START_NONE;
            op_q      <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            exp_lat_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_next;
            start_q   <= start_next;
            op_q      <= op_next;
            rd1_q     <= rd1_next;
            rd2_q     <= rd2_next;
            exp_lat_q <= exp_lat_next;
            error_q   <= error_next;
        end
    end

    // Next-state logic. The state-specific transitions come first; an accepted
    // request then overrides them, which can only happen from IDLE or from an
    // idle-unit WAIT cycle.
    always_comb begin
        state_next   = state;
        start_next   = start_q;
        op_next      = op_q;
        rd1_next     = rd1_q;
        rd2_next     = rd2_q;
        exp_lat_next = exp_lat_q;
        error_next   = error_q || lat_violation;

        case (state)
            ST_ISSUE: begin
                start_next = START_NONE;
                if (Flush) begin
                    state_next = ST_IDLE;
                end else if (op_is_muldiv(op_q)) begin
                    state_next = ST_WAIT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (accept && !op_is_read(ReqOp)) begin
            state_next = ST_ISSUE;
            op_next    = ReqOp;
            rd1_next   = ReqRs;
            if (op_is_muldiv(ReqOp)) begin
                start_next   = START_MD;
                rd2_next     = ReqRt;
                exp_lat_next = op_is_div(ReqOp) ? DIV_LAT : MULT_LAT;
            end else begin
                start_next   = START_HILO;
                exp_lat_next = '0;
            end
        end
    end

    assign Stall    = ReqValid && ((state == ST_ISSUE) || ((state == ST_WAIT) && MdBusy));
    assign MdEnable = (state == ST_ISSUE) && !Flush;
    assign MdStart  = start_q;
    assign MdOp     = op_q;
    assign MdRD1    = rd1_q;
    assign MdRD2    = rd2_q;
    assign Error    = error_q;

    // The read path is purely combinational, so it is gated with Reset_n to
    // keep it quiet while reset is asserted.
    assign ReadValid = Reset_n && accept && op_is_read(ReqOp);
    assign ReadData  = ReadValid ? ((ReqOp == MD_MFHI) ? MdHI : MdLO) : 32'd0;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_issue_ctrl
//
// Directed bench for md_issue_ctrl. A small behavioural model of the
// multiply/divide unit answers start commands with a busy window of
// configurable length and updates HI/LO when the window closes.
// ---------------------------------------------------------------------------
module tb_md_issue_ctrl;

    logic        Clock;
    logic        Reset_n;
    logic        ReqValid;
    logic [2:0]  ReqOp;
    logic [31:0] ReqRs;
    logic [31:0] ReqRt;
    logic        Flush;
    logic        Stall;
    logic [1:0]  MdStart;
    logic        MdEnable;
    logic [2:0]  MdOp;
    logic [31:0] MdRD1;
    logic [31:0] MdRD2;
    logic        MdBusy;
    logic [31:0] MdHI;
    logic [31:0] MdLO;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        Error;

    int check_count = 0;
    int error_count = 0;

    // Unit model controls: -1 uses the nominal latency, otherwise this length
    int busy_override = -1;
    int busy_cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    int stall_n;
    int start_n;

    md_issue_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .TIMEOUT     (16)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .ReqValid  (ReqValid),
        .ReqOp     (ReqOp),
        .ReqRs     (ReqRs),
        .ReqRt     (ReqRt),
        .Flush     (Flush),
        .Stall     (Stall),
        .MdStart   (MdStart),
        .MdEnable  (MdEnable),
        .MdOp      (MdOp),
        .MdRD1     (MdRD1),
        .MdRD2     (MdRD2),
        .MdBusy    (MdBusy),
        .MdHI      (MdHI),
        .MdLO      (MdLO),
        .ReadData  (ReadData),
        .ReadValid (ReadValid),
        .Error     (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Arithmetic of the unit itself: {HI, LO}
    function automatic logic [63:0] unitResult(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        int a_s;
        int b_s;
        longint p_s;
        logic [63:0] p_u;
        logic [63:0] res;
        a_s = a;
        b_s = b;
        res = 64'd0;
        case (op)
            3'd0: begin
                p_s = longint'(a_s) * longint'(b_s);
                res = p_s;
            end
            3'd1: begin
                p_u = {32'd0, a} * {32'd0, b};
                res = p_u;
            end
            3'd2: if (b_s != 0) res = {32'(a_s % b_s), 32'(a_s / b_s)};
            3'd3: if (b != 0)   res = {a % b, a / b};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Unit model: samples a start on MdEnable, holds busy for the latency,
    // writes HI/LO on the edge that ends the busy window.
    assign MdBusy = (busy_cnt != 0);

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_cnt <= 0;
            MdHI     <= 32'd0;
            MdLO     <= 32'd0;
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    MdHI <= pend_hi;
                    MdLO <= pend_lo;
                end
            end
            if (MdEnable && MdStart == 2'd1) begin
                {pend_hi, pend_lo} <= unitResult(MdOp, MdRD1, MdRD2);
                if (busy_override >= 0)
                    busy_cnt <= busy_override;
                else
                    busy_cnt <= (MdOp >= 3'd2) ? 10 : 5;
            end else if (MdEnable && MdStart == 2'd2) begin
                if (MdOp == 3'd4) MdHI <= MdRD1;
                else              MdLO <= MdRD1;
            end
        end
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of request inputs just after the rising edge, then
    // settle at the falling edge where outputs are sampled.
    task automatic applyStimulus(input logic valid, input logic [2:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic flush);
        @(posedge Clock);
        #1;
        ReqValid = valid;
        ReqOp    = op;
        ReqRs    = rs;
        ReqRt    = rt;
        Flush    = flush;
        @(negedge Clock);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    // Counts consecutive stalled cycles (bounded) and the MdStart cycles among them
    task automatic countStall(output int stall_cycles, output int start_cycles);
        stall_cycles = 0;
        start_cycles = 0;
        while (Stall === 1'b1 && stall_cycles < 40) begin
            stall_cycles++;
            if (MdStart !== 2'd0) start_cycles++;
            @(negedge Clock);
        end
    endtask

    task automatic doReset();
        @(posedge Clock);
        #1;
        Reset_n  = 1'b0;
        ReqValid = 1'b0;
        Flush    = 1'b0;
        busy_override = -1;
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        @(negedge Clock);
    endtask

    // Watchdog so the bench always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset_n  = 1'b0;
        ReqValid = 1'b0;
        ReqOp    = 3'd0;
        ReqRs    = 32'd0;
        ReqRt    = 32'd0;
        Flush    = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        @(negedge Clock);

        // Reset state
        checkOutput("reset Stall",     Stall,     0);
        checkOutput("reset MdStart",   MdStart,   0);
        checkOutput("reset MdEnable",  MdEnable,  0);
        checkOutput("reset MdOp",      MdOp,      0);
        checkOutput("reset MdRD1",     MdRD1,     0);
        checkOutput("reset MdRD2",     MdRD2,     0);
        checkOutput("reset Error",     Error,     0);
        checkOutput("reset ReadValid", ReadValid, 0);
        checkOutput("reset ReadData",  ReadData,  0);

        // mult 7 * -3, then mflo
        $display("[TB] mult 7, -3 followed by mflo");
        applyStimulus(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        checkOutput("mult idle Stall", Stall, 0);
        applyStimulus(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
        checkOutput("mult MdStart",  MdStart,  1);
        checkOutput("mult MdEnable", MdEnable, 1);
        checkOutput("mult MdOp",     MdOp,     0);
        checkOutput("mult MdRD1",    MdRD1,    32'd7);
        checkOutput("mult MdRD2",    MdRD2,    32'hFFFF_FFFD);
        countStall(stall_n, start_n);
        checkOutput("mult stall cycles", stall_n, 6);
        checkOutput("mult start cycles", start_n, 1);
        checkOutput("mflo ReadValid",    ReadValid, 1);
        checkOutput("mflo ReadData",     ReadData,  32'hFFFF_FFEB);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("mult Error", Error, 0);

        // divu 100 / 7, then mfhi
        $display("[TB] divu 100, 7 followed by mfhi");
        applyStimulus(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        applyStimulus(1'b1, 3'd6, 32'd0, 32'd0, 1'b0);
        checkOutput("divu MdOp", MdOp, 3);
        countStall(stall_n, start_n);
        checkOutput("divu stall cycles", stall_n, 11);
        checkOutput("mfhi ReadValid",    ReadValid, 1);
        checkOutput("mfhi ReadData",     ReadData,  32'd2);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("divu Error", Error, 0);

        // mthi, then mfhi
        $display("[TB] mthi followed by mfhi");
        applyStimulus(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        applyStimulus(1'b1, 3'd6, 32'd0, 32'd0, 1'b0);
        checkOutput("mthi MdStart", MdStart, 2);
        checkOutput("mthi MdRD1",   MdRD1,   32'h1234_5678);
        checkOutput("mthi MdOp",    MdOp,    4);
        countStall(stall_n, start_n);
        checkOutput("mthi stall cycles", stall_n, 1);
        checkOutput("mthi ReadData",     ReadData, 32'h1234_5678);
        checkOutput("mthi ReadValid",    ReadValid, 1);

        // Flush in the ISSUE cycle of a div
        $display("[TB] flush during issue");
        applyStimulus(1'b1, 3'd2, 32'd50, 32'd5, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("flush MdEnable", MdEnable, 0);
        applyStimulus(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
        checkOutput("flush mflo Stall",     Stall,     0);
        checkOutput("flush mflo ReadValid", ReadValid, 1);
        checkOutput("flush mflo ReadData",  ReadData,  32'd14);
        checkOutput("flush unit not started", MdBusy, 0);

        // Flush together with a request: nothing issued
        $display("[TB] flush with request");
        applyStimulus(1'b1, 3'd0, 32'd9, 32'd9, 1'b1);
        checkOutput("flushreq ReadValid", ReadValid, 0);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("flushreq MdStart",  MdStart,  0);
        checkOutput("flushreq MdEnable", MdEnable, 0);
        checkOutput("flushreq Error",    Error,    0);

        // Back-to-back mult accepted in the first free cycle
        $display("[TB] back-to-back mult");
        applyStimulus(1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
        applyStimulus(1'b1, 3'd0, 32'd5, 32'd6, 1'b0);
        checkOutput("b2b first MdRD1", MdRD1, 32'd2);
        countStall(stall_n, start_n);
        checkOutput("b2b stall cycles", stall_n, 6);
        checkOutput("b2b free ReadValid", ReadValid, 0);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("b2b second MdStart", MdStart, 1);
        checkOutput("b2b second MdRD1",   MdRD1,   32'd5);
        checkOutput("b2b second MdRD2",   MdRD2,   32'd6);
        idleCycles(8);
        applyStimulus(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
        checkOutput("b2b mflo ReadData", ReadData, 32'd30);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("b2b Error", Error, 0);

        // Busy window too short
        $display("[TB] short busy window");
        busy_override = 4;
        applyStimulus(1'b1, 3'd0, 32'd1, 32'd1, 1'b0);
        idleCycles(8);
        checkOutput("short busy Error", Error, 1);
        doReset();
        checkOutput("Error cleared by reset", Error, 0);

        // Unit never goes busy
        $display("[TB] unit never busy");
        busy_override = 0;
        applyStimulus(1'b1, 3'd0, 32'd1, 32'd1, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 3'd6, 32'd0, 32'd0, 1'b0);
        checkOutput("nobusy Stall",     Stall,     0);
        checkOutput("nobusy Error pre", Error,     0);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("nobusy Error",     Error,     1);
        doReset();

        // Unit stays busy past the timeout
        $display("[TB] timeout");
        busy_override = 30;
        applyStimulus(1'b1, 3'd0, 32'd1, 32'd1, 1'b0);
        applyStimulus(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
        countStall(stall_n, start_n);
        checkOutput("timeout stall cycles", stall_n, 17);
        checkOutput("timeout Error",        Error,   1);
        doReset();

        // Reset asserted during WAIT of a mult
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 3'd0, 32'd8, 32'd8, 1'b0);
        applyStimulus(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
        @(negedge Clock);
        checkOutput("midreset Stall before", Stall, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("midreset Stall",     Stall,     0);
        checkOutput("midreset MdStart",   MdStart,   0);
        checkOutput("midreset MdEnable",  MdEnable,  0);
        checkOutput("midreset MdOp",      MdOp,      0);
        checkOutput("midreset MdRD1",     MdRD1,     0);
        checkOutput("midreset MdRD2",     MdRD2,     0);
        checkOutput("midreset Error",     Error,     0);
        checkOutput("midreset ReadValid", ReadValid, 0);
        checkOutput("midreset ReadData",  ReadData,  0);
        ReqValid = 1'b0;
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        applyStimulus(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
        applyStimulus(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
        checkOutput("postreset MdStart", MdStart, 1);
        checkOutput("postreset MdRD1",   MdRD1,   32'd3);
        countStall(stall_n, start_n);
        checkOutput("postreset stall cycles", stall_n, 6);
        checkOutput("postreset ReadData",     ReadData, 32'd12);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("postreset Error", Error, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Pipeline-side initiator for the multiply/divide unit. It accepts multiply/divide-class instructions from the EX stage and issues start pulses, opcodes and operands to the unit. It tracks the unit's busy window with its own state machine and latency counter, and stalls the pipeline while a result is pending. It also serves mfhi/mflo reads, cancels an issue on an exception flush, and flags protocol or latency violations.

## Interface

Parameters:
- MULT_CYCLES, 5, cycles MdBusy stays high for mult/multu
- DIV_CYCLES, 10, cycles MdBusy stays high for div/divu
- TIMEOUT, 16, WAIT-cycle limit before declaring Error

Ports:
- Clock  in  1  single clock; all state updates on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ReqValid  in  1  EX stage holds a multiply/divide-class instruction
- ReqOp  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
- ReqRs, ReqRt  in  32  operands
- Flush  in  1  kill the EX instruction (exception/interrupt)
- Stall  out  1  freeze F/D/E stages (combinational)
- MdStart  out  2  0 none, 1 mult/div start, 2 HI/LO write
- MdEnable  out  1  qualifies MdStart
- MdOp  out  3  unit opcode (0–5, same encoding as ReqOp)
- MdRD1, MdRD2  out  32  operands to the unit
- MdBusy  in  1  unit busy
- MdHI, MdLO  in  32  unit result registers
- ReadData  out  32  mfhi/mflo result (combinational)
- ReadValid  out  1  ReadData is valid this cycle
- Error  out  1  sticky protocol/latency violation

## Operation

- **States:** IDLE, ISSUE, WAIT.
- **Stall:** Stall = ReqValid & ((state==ISSUE) | (state==WAIT & MdBusy)).
- **Free:** the controller is free when state==IDLE, or state==WAIT with MdBusy==0.
- **Acceptance:** a request is accepted on an edge where it is free, ReqValid=1 and Flush=0.
- **Accepted op 0–3:**
  - register MdOp=ReqOp, MdRD1=ReqRs, MdRD2=ReqRt, MdStart=1;
  - go to ISSUE;
  - expected latency = MULT_CYCLES (ops 0–1) or DIV_CYCLES (ops 2–3).
- **Accepted op 4–5:** register MdStart=2, MdOp and MdRD1=ReqRs; go to ISSUE with expected latency 0.
- **Accepted op 6–7:** no state change. ReadData = MdHI (op 6) or MdLO (op 7). ReadValid = 1 in the free cycle with ReqValid=1 and Flush=0.
- **ISSUE (exactly 1 cycle):**
  - MdEnable = !Flush.
  - Flush=1 cancels the operation: go to IDLE.
  - Otherwise go to WAIT for ops 0–3, or to IDLE for ops 4–5.
  - MdStart clears on leaving ISSUE.
- **WAIT:**
  - Count increments on each edge with MdBusy=1.
  - MdBusy=0 on the first WAIT cycle sets Error and moves to IDLE.
  - MdBusy falling while count != expected latency sets Error.
  - Count reaching TIMEOUT sets Error and moves to IDLE.
  - Flush has no effect; the operation is already committed.
- **Leaving WAIT:** WAIT with MdBusy=0 behaves exactly as IDLE, including accepting a new request, then moves to IDLE or ISSUE.
- **Error:** set by any violation above, cleared only by reset.

## Timing

- **Reset values:**
  - state = IDLE, count = 0;
  - MdStart, MdEnable, MdOp, MdRD1, MdRD2 = 0;
  - Error = 0, Stall = 0, ReadValid = 0, ReadData = 0.
- **Reset mid-operation:** aborts immediately. No issue is replayed; the unit is reset independently.
- **mult/div sequence:**
  - request accepted at edge k;
  - MdStart=1 during cycle k..k+1; the unit samples it at edge k+1;
  - MdBusy is high for N cycles after edge k+1;
  - a dependent mfhi/mflo stalls N+1 cycles and reads the result in the first cycle where MdBusy=0.
- **mthi/mtlo:** a following md-class request stalls exactly 1 cycle.
- **Back-to-back ops:** a mult/div issued while free is accepted with no bubble.
- **Flush with ReqValid in the same cycle:** the request is not accepted and nothing is issued.

## Structure

- Shared package holds:
  - ReqOp encodings (MD_MULT..MD_MFLO);
  - MdStart encodings (START_NONE, START_MD, START_HILO);
  - opcode width constant (3);
  - state encoding.
- One sub-module, md_latency_check: WAIT counter, expected-latency compare and timeout. It outputs `done` and `violation`.

## Test plan

- **mult:** mult 7, −3 (Rt=0xFFFFFFFD) followed by mflo.
  - MdStart=1 for 1 cycle, MdOp=0, MdRD2=0xFFFFFFFD.
  - Stall for 6 cycles.
  - ReadData=0xFFFFFFEB, ReadValid=1. Error=0.
- **divu:** divu 100, 7 followed by mfhi → stall for 11 cycles, then ReadData=2.
- **mthi:** mthi 0x12345678 followed by mfhi.
  - MdStart=2 with MdRD1=0x12345678.
  - Stall for 1 cycle, then ReadData=0x12345678.
- **Flush during ISSUE:** assert Flush in the ISSUE cycle of a div.
  - MdEnable=0, return to IDLE.
  - A following mflo is not stalled.
- **Latency violations (ReqOp=0 issued):** unit model holds MdBusy for 4 cycles → Error=1. Separately, unit model never asserts MdBusy → Error=1 and IDLE the next cycle.
- **Reset mid-operation:** Reset_n low during WAIT of a mult → all outputs 0 asynchronously, and a request after release is accepted normally.
